// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings, Q8.8 limits and Q16.16 -> Q8.8 saturation
package mdu_pkg;

   typedef enum logic {OP_MUL = 1'b0, OP_DIV = 1'b1} op_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] Q88_MAX = 16'h7FFF;
   localparam logic [15:0] Q88_MIN = 16'h8000;

   // {err, data}: the Q8.8 window is bits [23:8]; anything above must be pure sign extension
   function automatic logic [16:0] sat_q1616_to_q88(input logic [31:0] v);
      logic [15:0] w_mid;
      w_mid = 16'(v >> 8);
      return (&v[31:23] || ~|v[31:23]) ? {1'b0, w_mid} : {1'b1, v[31] ? Q88_MIN : Q88_MAX};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; the requester named by rr wins when both ask
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_rr,
   output logic [1:0] o_gnt
);
   assign o_gnt = i_req[i_rr]  ? (i_rr ? 2'b10 : 2'b01) :
                  i_req[!i_rr] ? (i_rr ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: shares one multiplier and one divider between two Q8.8 requesters,
// one operation in flight, with Q8.8 <-> Q16.16 conversion and a watchdog timeout
module mdu_scheduler
   import mdu_pkg::*;
#(
   parameter int TIMEOUT  = 63,
   parameter int FBITS_IN = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a0,
   input  logic [15:0] req_b0,
   input  logic [15:0] req_a1,
   input  logic [15:0] req_b1,
   output logic [1:0]  gnt,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        mul_stb,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   input  logic        mul_busy,
   input  logic        mul_done,
   input  logic [31:0] mul_p,
   output logic        div_start,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_busy,
   input  logic        div_done,
   input  logic        div_valid,
   input  logic        div_dbz,
   input  logic        div_ovf,
   input  logic [31:0] div_val
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        r_state, w_next;
   op_t           r_op;
   logic          r_win, r_rr, r_err;
   logic [15:0]   r_a, r_b, r_data;
   logic [CW-1:0] r_cnt;
   logic [1:0]    w_arb;
   logic          w_win, w_busy, w_done, w_tmo;
   logic [16:0]   w_res;

   rr_arb2 u_arb (
      .i_req (req),
      .i_rr  (r_rr),
      .o_gnt (w_arb)
   );

   assign w_win  = w_arb[1];
   assign w_busy = (r_op == OP_MUL) ? mul_busy : div_busy;
   assign w_done = (r_op == OP_MUL) ? mul_done : div_done;
   assign w_tmo  = (r_cnt + CW'(1)) == CW'(TIMEOUT - 1);
   assign w_res  = (r_op == OP_MUL) ? sat_q1616_to_q88(mul_p) :
                   (div_dbz || div_ovf || !div_valid) ? {1'b1, 16'h0000} : sat_q1616_to_q88(div_val);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (|req) ? ISSUE : IDLE;
         ISSUE:   w_next = w_busy ? ISSUE : WAIT;
         WAIT:    w_next = (w_done || w_tmo) ? RESP : WAIT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op   <= OP_MUL;
         r_win  <= 1'b0;
         r_rr   <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (r_state == IDLE && |req) begin
            r_win <= w_win;
            r_op  <= op_t'(req_op[w_win]);
            r_a   <= w_win ? req_a1 : req_a0;
            r_b   <= w_win ? req_b1 : req_b0;
         end
         if (r_state == ISSUE && !w_busy) r_cnt <= '0;
         if (r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_done)     {r_err, r_data} <= w_res;
            else if (w_tmo) {r_err, r_data} <= {1'b1, 16'h0000};
         end
         if (r_state == RESP) r_rr <= ~r_win;
      end
   end

   // gnt is masked during reset so a held request is first granted when reset drops
   always_comb begin
      gnt       = (r_state == IDLE && !reset) ? w_arb : 2'b00;
      rsp_valid = (r_state == RESP) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
      rsp_data  = r_data;
      rsp_err   = r_err;
      mul_stb   = r_state == ISSUE && r_op == OP_MUL && !mul_busy;
      div_start = r_state == ISSUE && r_op == OP_DIV && !div_busy;
      mul_a     = r_a;
      mul_b     = r_b;
      div_a     = {{(16 - FBITS_IN){r_a[15]}}, r_a, {FBITS_IN{1'b0}}};
      div_b     = {{(16 - FBITS_IN){r_b[15]}}, r_b, {FBITS_IN{1'b0}}};
   end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Shares one `slowmpy` multiplier and one `div` divider between two Q8.8 requesters (e.g. object-transform logic and UART command logic).
- Arbitrates round-robin with one operation in flight.
- Converts Q8.8 operands into engine formats and engine results back to saturated Q8.8.
- Guards each operation with a watchdog timeout.
- Sits in the top level between the requesters and the engine instances.

Parameters:
- TIMEOUT, 63: max WAIT cycles before forced error completion.
- FBITS_IN, 8: fraction bits of requester operands/results (fixed Q8.8; other values unsupported).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held with operands until gnt.
- req_op  in  2  per-requester op: 0 = mul, 1 = div.
- req_a0, req_b0  in  16  requester 0 operands, signed Q8.8.
- req_a1, req_b1  in  16  requester 1 operands, signed Q8.8.
- gnt  out  2  one-cycle accept pulse, one-hot.
- rsp_valid  out  2  one-cycle result pulse, one-hot.
- rsp_data  out  16  signed Q8.8 result, valid with rsp_valid.
- rsp_err  out  1  saturation/dbz/ovf/timeout flag, valid with rsp_valid.
- mul_stb  out  1  to slowmpy i_stb.
- mul_a, mul_b  out  16  to slowmpy operands.
- mul_busy, mul_done  in  1  from slowmpy.
- mul_p  in  32  slowmpy product (Q16.16).
- div_start  out  1  to div start.
- div_a, div_b  out  32  Q16.16 operands.
- div_busy, div_done, div_valid, div_dbz, div_ovf  in  1  from div.
- div_val  in  32  Q16.16 quotient.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, rr pointer = 0, timeout counter = 0.
  - gnt, rsp_valid, rsp_err, mul_stb, div_start = 0; rsp_data = 0; latched operands = 0.
  - Reset mid-operation abandons it: no rsp_valid is ever issued for it. Engine outputs are ignored until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is set: winner = requester at rr if requesting, else the other.
  - gnt[winner] = 1 combinationally this cycle.
  - Latch op, operands and winner index; go to ISSUE.
- ISSUE:
  - Wait while the target engine's busy is 1.
  - Otherwise assert mul_stb or div_start for exactly one cycle, clear the counter, go to WAIT.
- WAIT:
  - Target done = 1 → capture the converted result, go to RESP.
  - Otherwise increment the counter; at counter == TIMEOUT-1 go to RESP with err = 1, data = 0.
  - A done from the non-target engine is ignored.
- RESP:
  - rsp_valid[winner] = 1 for one cycle with rsp_data/rsp_err.
  - rr = ~winner; go to IDLE.
  - A new grant is possible the cycle after RESP, so there is at most one gnt per 4 cycles.
- Latency: req in IDLE at cycle T → strobe at T+1 (engine idle) → done at T+1+L → rsp_valid at T+2+L.
- Multiply conversion:
  - mul_a/mul_b = latched Q8.8 operands.
  - Result = mul_p[23:8].
  - If mul_p[31:23] is not all-equal: saturate to 16'h7FFF (mul_p[31] = 0) or 16'h8000 (mul_p[31] = 1), err = 1.
- Divide conversion:
  - div_a = {{8{a[15]}}, a, 8'h00}; div_b likewise.
  - div_dbz, div_ovf or !div_valid → data 0, err = 1.
  - Else result = div_val[23:8], saturated on div_val[31:23] exactly as for multiply.
- rsp_data/rsp_err hold their value between pulses.
- Requesters must keep req/operands stable until gnt; changes before gnt are sampled only in the grant cycle.

Decomposition:
- Package mdu_pkg holds:
  - op encodings OP_MUL/OP_DIV;
  - state encodings;
  - Q8.8 constants Q88_MAX = 16'h7FFF, Q88_MIN = 16'h8000;
  - helper function sat_q1616_to_q88(input [31:0]) returning {err, data}.
- One sub-module, rr_arb2: 2-way round-robin picker (req, rr → one-hot grant).

Test Plan:
- Req0 mul with a = 16'hEC14, b = 16'hFE0C; model mul latency 19, mul_p = 32'h0026E8F0 → gnt = 2'b01; mul_stb one cycle later; rsp_valid = 2'b01 at T+21; rsp_data = 16'h26E8; rsp_err = 0.
- Req1 div with a = 16'h0C00, b = 16'h0F00 → div_a = 32'h000C0000, div_b = 32'h000F0000; model div_val = 32'h0000CCCC → rsp_data = 16'h00CC, err = 0.
- Mul a = 16'h7F00, b = 16'h0200 (mul_p = 32'h00FE0000) → rsp_data = 16'h7FFF, err = 1. Div with b = 0, model div_dbz = 1 → data 0, err = 1.
- Both req set continuously from reset → grants alternate 01, 10, 01, 10; each rsp_valid bit matches its own grant.
- Engine model never asserts done, TIMEOUT = 63 → rsp_valid 63 cycles after the strobe, data 0, err = 1. Force mul_busy = 1 for 5 cycles in ISSUE → mul_stb delayed until busy drops.
- Assert reset during WAIT → all outputs 0 next cycle; no rsp_valid for the aborted op; a fresh req is granted in the cycle reset is released.
